// File: rtl/block_lock_gen.sv
// Sync-header block aligner and lock FSM for a 64b/66b-style PCS receive path.
// Latency 2 clk data_in_valid -> data_out_valid; no backpressure, gaps in data_in_valid stall the hunt/lock counters.
module block_lock_gen #(
    parameter int BLOCK_W   = 66,
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 1024,
    parameter int INVLD_MAX = 16,
    parameter int SLIP_WAIT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic               data_in_valid,
    output logic [BLOCK_W-1:0] data_out,
    output logic               data_out_valid,
    output logic               sh_valid,
    output logic               block_lock,
    output logic               lock_lost,
    output logic [7:0]         slip_cnt
);
    localparam int SH_MAX = (LOCK_CNT > WINDOW) ? LOCK_CNT : WINDOW;
    localparam int SH_W   = $clog2(SH_MAX + 1);
    localparam int INV_W  = $clog2(INVLD_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
    localparam int POS_W  = $clog2(BLOCK_W);

    localparam logic [POS_W:0]    W_VAL    = BLOCK_W[POS_W:0];
    localparam logic [POS_W-1:0]  LAST_POS = POS_W'(BLOCK_W - 1);
    localparam logic [SH_W-1:0]   LOCK_V   = LOCK_CNT[SH_W-1:0];
    localparam logic [SH_W-1:0]   WIN_V    = WINDOW[SH_W-1:0];
    localparam logic [INV_W-1:0]  INV_V    = INVLD_MAX[INV_W-1:0];
    localparam logic [WAIT_W-1:0] WAIT_V   = SLIP_WAIT[WAIT_W-1:0];

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RESET_CNT,
        ST_TEST_SH,
        ST_TEST_SH2,
        ST_SLIP_WAIT
    } state_t;

    state_t               state, state_nxt;
    logic [2*BLOCK_W-1:0] buffer;
    logic                 buf_vld;
    logic [POS_W-1:0]     position;
    logic [POS_W:0]       sel_base;
    logic [BLOCK_W-1:0]   candidate;
    logic                 hdr_ok;
    logic [SH_W-1:0]      sh_cnt, sh_nxt, sh_inc;
    logic [INV_W-1:0]     invld_cnt, invld_nxt, invld_new;
    logic [WAIT_W-1:0]    wait_cnt, wait_nxt, wait_inc;
    logic                 lock_nxt, lost_nxt, slip;

    // Older word sits in the low half; a larger position reaches further back in line time.
    assign sel_base  = W_VAL - {1'b0, position};
    assign candidate = buffer[sel_base +: BLOCK_W];
    assign hdr_ok    = candidate[0] ^ candidate[1];
    assign sh_inc    = sh_cnt + SH_W'(1);
    assign wait_inc  = wait_cnt + WAIT_W'(1);
    assign invld_new = hdr_ok ? invld_cnt : invld_cnt + INV_W'(1);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh_cnt;
        invld_nxt = invld_cnt;
        wait_nxt  = wait_cnt;
        lock_nxt  = block_lock;
        lost_nxt  = 1'b0;
        slip      = 1'b0;
        case (state)
            ST_INIT: begin
                lock_nxt  = 1'b0;
                sh_nxt    = '0;
                invld_nxt = '0;
                wait_nxt  = '0;
                state_nxt = ST_RESET_CNT;
            end
            ST_RESET_CNT: begin
                sh_nxt    = '0;
                invld_nxt = '0;
                state_nxt = block_lock ? ST_TEST_SH2 : ST_TEST_SH;
            end
            ST_TEST_SH: begin
                if (buf_vld) begin
                    if (!hdr_ok) begin
                        slip      = 1'b1;
                        sh_nxt    = '0;
                        wait_nxt  = '0;
                        state_nxt = ST_SLIP_WAIT;
                    end else begin
                        sh_nxt = sh_inc;
                        if (sh_inc == LOCK_V) begin
                            lock_nxt  = 1'b1;
                            state_nxt = ST_RESET_CNT;
                        end
                    end
                end
            end
            ST_TEST_SH2: begin
                if (buf_vld) begin
                    sh_nxt    = sh_inc;
                    invld_nxt = invld_new;
                    // Loss outranks window completion on the same block.
                    if (invld_new == INV_V) begin
                        lock_nxt  = 1'b0;
                        lost_nxt  = 1'b1;
                        slip      = 1'b1;
                        wait_nxt  = '0;
                        state_nxt = ST_SLIP_WAIT;
                    end else if (sh_inc == WIN_V) begin
                        state_nxt = ST_RESET_CNT;
                    end
                end
            end
            ST_SLIP_WAIT: begin
                if (SLIP_WAIT == 0) begin
                    state_nxt = ST_RESET_CNT;
                end else if (buf_vld) begin
                    wait_nxt = wait_inc;
                    if (wait_inc == WAIT_V) state_nxt = ST_RESET_CNT;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buffer         <= '0;
            buf_vld        <= 1'b0;
            position       <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            sh_valid       <= 1'b0;
            block_lock     <= 1'b0;
            lock_lost      <= 1'b0;
            slip_cnt       <= 8'd0;
            sh_cnt         <= '0;
            invld_cnt      <= '0;
            wait_cnt       <= '0;
        end else begin
            if (data_in_valid) buffer <= {data_in, buffer[2*BLOCK_W-1:BLOCK_W]};
            buf_vld        <= data_in_valid;
            data_out_valid <= buf_vld;
            if (buf_vld) begin
                data_out <= candidate;
                sh_valid <= hdr_ok;
            end
            // The block that caused the slip has already been taken at the old offset.
            if (slip) begin
                position <= (position == LAST_POS) ? '0 : position + POS_W'(1);
                if (slip_cnt != 8'hFF) slip_cnt <= slip_cnt + 8'd1;
            end
            block_lock <= lock_nxt;
            lock_lost  <= lost_nxt;
            sh_cnt     <= sh_nxt;
            invld_cnt  <= invld_nxt;
            wait_cnt   <= wait_nxt;
        end
    end
endmodule

// File: tb/tb_block_lock_gen.sv
// Scoreboard bench for block_lock_gen: default instance plus a small-threshold instance.
module tb_block_lock_gen;
    localparam int W   = 66;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, data_in_valid, data_out_valid, sh_valid, block_lock, lock_lost;
    logic [W-1:0] data_in, data_out;
    logic [7:0]   slip_cnt;
    logic         reset2, data_in_valid2, data_out_valid2, sh_valid2, block_lock2, lock_lost2;
    logic [W-1:0] data_in2, data_out2;
    logic [7:0]   slip_cnt2;

    block_lock_gen dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_out(data_out), .data_out_valid(data_out_valid), .sh_valid(sh_valid),
        .block_lock(block_lock), .lock_lost(lock_lost), .slip_cnt(slip_cnt)
    );

    block_lock_gen #(.BLOCK_W(W), .LOCK_CNT(4), .WINDOW(8), .INVLD_MAX(2), .SLIP_WAIT(0)) dut2 (
        .clk(clk), .reset(reset2), .data_in(data_in2), .data_in_valid(data_in_valid2),
        .data_out(data_out2), .data_out_valid(data_out_valid2), .sh_valid(sh_valid2),
        .block_lock(block_lock2), .lock_lost(lock_lost2), .slip_cnt(slip_cnt2)
    );

    // mode 0: count only; 1: full compare; 2: compare data only while locked
    typedef struct {
        logic [W-1:0] dat;
        logic         shv;
        logic         lock;
        logic         lost;
        int           mode;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    int          total  = 0;
    int          bad    = 0;
    int          lk_cmp = 0;
    logic [63:0] xs     = 64'h9E3779B97F4A7C15;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic cmp(input int which, input exp_t e, input logic [W-1:0] d,
                       input logic s, input logic l, input logic ll);
        if (e.mode == 1) begin
            check($sformatf("dut%0d_data", which), d, e.dat);
            check($sformatf("dut%0d_sh_valid", which), s, e.shv);
            check($sformatf("dut%0d_block_lock", which), l, e.lock);
            check($sformatf("dut%0d_lock_lost", which), ll, e.lost);
        end else if (e.mode == 2 && l) begin
            lk_cmp++;
            check($sformatf("dut%0d_locked_data", which), d, e.dat);
            check($sformatf("dut%0d_locked_sh_valid", which), s, e.shv);
        end
    endtask

    always @(negedge clk) begin
        if (data_out_valid) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL dut1_extra_block: got block %0h, required none", data_out);
            end else cmp(1, q1.pop_front(), data_out, sh_valid, block_lock, lock_lost);
        end
    end

    always @(negedge clk) begin
        if (data_out_valid2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL dut2_extra_block: got block %0h, required none", data_out2);
            end else cmp(2, q2.pop_front(), data_out2, sh_valid2, block_lock2, lock_lost2);
        end
    end

    function automatic logic [63:0] xnext(input logic [63:0] x);
        logic [63:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    function automatic bit is_bad(input int sel, input int i);
        if (sel == 1)
            return (i >= 100 && i <= 114) || (i >= 1100 && i <= 1114) || (i >= 2200 && i <= 2215);
        if (sel == 2) return (i == 6) || (i == 15) || (i == 17);
        return 1'b0;
    endfunction

    task automatic gen_block(input bit badh, output logic [W-1:0] b);
        xs = xnext(xs);
        b[1:0] = badh ? 2'b00 : (xs[40] ? 2'b01 : 2'b10);
        xs = xnext(xs);
        b[W-1:2] = xs;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input int which, input logic [W-1:0] w, input exp_t e);
        if (which == 1) begin
            data_in = w; data_in_valid = 1'b1; q1.push_back(e);
        end else begin
            data_in2 = w; data_in_valid2 = 1'b1; q2.push_back(e);
        end
        @(posedge clk); #1;
        data_in_valid  = 1'b0;
        data_in_valid2 = 1'b0;
    endtask

    // Line stream: d filler bits, then blocks; words cut every W bits, bit 0 earliest.
    task automatic run_stream(input int which, input int d, input int n, input int gap,
                              input int bad_sel, input int lock_from, input int lost_at);
        logic         bits[$];
        logic [W-1:0] blks[$];
        logic [W-1:0] b, w;
        exp_t         e;
        for (int k = 0; k < d; k++) begin xs = xnext(xs); bits.push_back(xs[3]); end
        for (int i = 0; i < n; i++) begin
            while (bits.size() < W) begin
                gen_block(is_bad(bad_sel, blks.size()), b);
                blks.push_back(b);
                for (int k = 0; k < W; k++) bits.push_back(b[k]);
            end
            for (int k = 0; k < W; k++) w[k] = bits.pop_front();
            if (d == 0) begin
                e.dat  = blks[i];
                e.shv  = blks[i][0] ^ blks[i][1];
                e.lock = (i >= lock_from) && (i < lost_at);
                e.lost = (i == lost_at);
                e.mode = (i <= lost_at) ? 1 : 0;
            end else begin
                e.dat  = (i > 0) ? blks[i-1] : '0;
                e.shv  = 1'b1;
                e.lock = 1'b0;
                e.lost = 1'b0;
                e.mode = (i > 0) ? 2 : 0;
            end
            send_word(which, w, e);
            idle(gap);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; data_in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_data_out", data_out, '0);
        check("rst_data_out_valid", data_out_valid, 1'b0);
        check("rst_sh_valid", sh_valid, 1'b0);
        check("rst_block_lock", block_lock, 1'b0);
        check("rst_lock_lost", lock_lost, 1'b0);
        check("rst_slip_cnt", slip_cnt, 8'd0);
        @(posedge clk); #1;
        q1.delete();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        data_in = '0; data_in2 = '0; data_in_valid = 1'b0; data_in_valid2 = 1'b0;
        @(posedge clk); #1;
        check("rst2_block_lock", block_lock2, 1'b0);
        check("rst2_data_out_valid", data_out_valid2, 1'b0);
        check("rst2_slip_cnt", slip_cnt2, 8'd0);

        // Aligned hunt, then 15/15 bad headers in two windows, then 16 in the third.
        do_reset();
        idle(3);
        run_stream(1, 0, 2219, 0, 1, 63, 2215);
        idle(4);
        check("a_queue_drained", q1.size(), 0);
        check("a_block_lock_after_loss", block_lock, 1'b0);
        check("a_lock_lost_one_cycle", lock_lost, 1'b0);
        check("a_slip_cnt", slip_cnt, 8'd1);

        // Gapped valid (1-0-0) during hunt, reset while locked, then relock.
        do_reset();
        idle(3);
        run_stream(1, 0, 120, 2, 0, 63, BIG);
        check("b_locked_before_reset", block_lock, 1'b1);
        check("b_queue_drained", q1.size(), 0);
        do_reset();
        idle(3);
        run_stream(1, 0, 70, 0, 0, 63, BIG);
        idle(4);
        check("b_relock_queue_drained", q1.size(), 0);

        // Misaligned streams: 17-bit and 1-bit offsets.
        do_reset();
        idle(3);
        lk_cmp = 0;
        run_stream(1, 17, 600, 0, 0, BIG, BIG);
        idle(4);
        check("c17_block_lock", block_lock, 1'b1);
        check("c17_slip_range", (slip_cnt >= 8'd1) && (slip_cnt <= 8'd65), 1'b1);
        check("c17_locked_blocks_seen", lk_cmp > 20, 1'b1);
        check("c17_queue_drained", q1.size(), 0);

        do_reset();
        idle(3);
        lk_cmp = 0;
        run_stream(1, 1, 800, 0, 0, BIG, BIG);
        idle(4);
        check("c1_block_lock", block_lock, 1'b1);
        check("c1_slip_range", (slip_cnt >= 8'd1) && (slip_cnt <= 8'd65), 1'b1);
        check("c1_locked_blocks_seen", lk_cmp > 20, 1'b1);
        check("c1_queue_drained", q1.size(), 0);

        // Small thresholds: lock on 4, lose on 2 bad within an 8-block window.
        reset2 = 1'b0;
        idle(3);
        run_stream(2, 0, 20, 0, 2, 3, 17);
        idle(4);
        check("d_queue_drained", q2.size(), 0);
        check("d_block_lock", block_lock2, 1'b0);
        check("d_lock_lost_one_cycle", lock_lost2, 1'b0);
        check("d_slip_cnt", slip_cnt2, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
